// File: rtl/sram_1rw_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_1rw_ctrl
// Brief    : Arbitrates read/write request streams onto a 1RW SRAM port, runs
//            an optional post-reset init sweep, returns reads via a 3-deep FIFO.
// Revision : 1.0
// ============================================================================
module sram_1rw_ctrl #(
    parameter int                ADDR_W        = 7,
    parameter int                DATA_W        = 8,
    parameter int                DEPTH         = 128,
    parameter bit                INIT_EN       = 1'b1,
    parameter logic [DATA_W-1:0] INIT_VAL      = '0,
    parameter int                MAX_WR_STREAK = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_req_valid,
    output logic              wr_req_ready,
    input  logic [ADDR_W-1:0] wr_req_addr,
    input  logic [DATA_W-1:0] wr_req_data,
    input  logic [DATA_W-1:0] wr_req_mask,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,
    output logic              rd_resp_valid,
    input  logic              rd_resp_ready,
    output logic [DATA_W-1:0] rd_resp_data,
    output logic              init_done,
    output logic              RW0_en,
    output logic              RW0_wmode,
    output logic [ADDR_W-1:0] RW0_addr,
    output logic [DATA_W-1:0] RW0_wmask,
    output logic [DATA_W-1:0] RW0_wdata,
    input  logic [DATA_W-1:0] RW0_rdata
);
    localparam int                  c_streak_w   = $clog2(MAX_WR_STREAK + 1);
    localparam logic [c_streak_w-1:0] c_streak_max = c_streak_w'(MAX_WR_STREAK);
    localparam logic [ADDR_W-1:0]   c_last_addr  = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_W-1:0]       r_init_addr;
    logic [c_streak_w-1:0]   r_streak;
    logic                    r_inflight;
    logic [1:0]              r_occ;
    logic [1:0]              r_head;
    logic [1:0]              r_tail;
    logic [DATA_W-1:0]       r_fifo [0:2];

    logic w_init;
    logic w_run;
    logic w_rd_elig;
    logic w_rd_grant;
    logic w_wr_grant;
    logic w_push;
    logic w_pop;

    function automatic logic [1:0] f_ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Reset gates every output so the port is quiet while reset is held.
    assign w_init = (r_state == ST_INIT) && !reset;
    assign w_run  = (r_state == ST_RUN) && !reset;

    // Eligibility counts the read already on its way from the SRAM.
    assign w_rd_elig  = w_run && (({1'b0, r_occ} + {2'b00, r_inflight}) < 3'd3);
    assign w_rd_grant = w_rd_elig && rd_req_valid && (!wr_req_valid || (r_streak == c_streak_max));
    assign w_wr_grant = w_run && wr_req_valid && !w_rd_grant;

    assign wr_req_ready = w_run && !w_rd_grant;
    assign rd_req_ready = w_rd_elig && !w_wr_grant;
    assign init_done    = w_run;

    assign w_push        = r_inflight;
    assign rd_resp_valid = (r_occ != 2'd0) && !reset;
    assign rd_resp_data  = rd_resp_valid ? r_fifo[r_head] : '0;
    assign w_pop         = rd_resp_valid && rd_resp_ready;

    always_comb begin
        w_state_nxt = r_state;
        if ((r_state == ST_INIT) && (r_init_addr == c_last_addr)) begin
            w_state_nxt = ST_RUN;
        end
    end

    always_comb begin
        RW0_en    = 1'b0;
        RW0_wmode = 1'b0;
        RW0_addr  = '0;
        RW0_wmask = '0;
        RW0_wdata = '0;
        if (w_init) begin
            RW0_en    = 1'b1;
            RW0_wmode = 1'b1;
            RW0_addr  = r_init_addr;
            RW0_wmask = '1;
            RW0_wdata = INIT_VAL;
        end else if (w_wr_grant) begin
            RW0_en    = 1'b1;
            RW0_wmode = 1'b1;
            RW0_addr  = wr_req_addr;
            RW0_wmask = wr_req_mask;
            RW0_wdata = wr_req_data;
        end else if (w_rd_grant) begin
            RW0_en    = 1'b1;
            RW0_addr  = rd_req_addr;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= INIT_EN ? ST_INIT : ST_RUN;
            r_init_addr <= '0;
            r_streak    <= '0;
            r_inflight  <= 1'b0;
            r_occ       <= 2'd0;
            r_head      <= 2'd0;
            r_tail      <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_rd_grant;
            if (r_state == ST_INIT) begin
                r_init_addr <= r_init_addr + 1'b1;
            end
            // Streak only measures how long an eligible read has been passed over.
            if (w_rd_grant || !(w_rd_elig && rd_req_valid)) begin
                r_streak <= '0;
            end else if (w_wr_grant && (r_streak != c_streak_max)) begin
                r_streak <= r_streak + 1'b1;
            end
            if (w_push) begin
                r_tail <= f_ptr_inc(r_tail);
            end
            if (w_pop) begin
                r_head <= f_ptr_inc(r_head);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo[r_tail] <= RW0_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_1rw_ctrl.sv
`default_nettype none
// Testbench for sram_1rw_ctrl: directed and random traffic scored against a
// transaction-level model (shadow memory + expected-response queue).
module tb_sram_1rw_ctrl;
    localparam int         DEPTH = 128;
    localparam int         MAXS  = 4;
    localparam logic [7:0] IV    = 8'hA5;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       wr_req_valid = 1'b0;
    logic       wr_req_ready;
    logic [6:0] wr_req_addr = '0;
    logic [7:0] wr_req_data = '0;
    logic [7:0] wr_req_mask = '0;
    logic       rd_req_valid = 1'b0;
    logic       rd_req_ready;
    logic [6:0] rd_req_addr = '0;
    logic       rd_resp_valid;
    logic       rd_resp_ready = 1'b1;
    logic [7:0] rd_resp_data;
    logic       init_done;
    logic       RW0_en, RW0_wmode;
    logic [6:0] RW0_addr;
    logic [7:0] RW0_wmask, RW0_wdata;
    logic [7:0] RW0_rdata = '0;

    int checks   = 0;
    int failures = 0;
    int gcyc     = 0;

    always #5 clock = ~clock;
    always @(posedge clock) gcyc <= gcyc + 1;

    sram_1rw_ctrl #(
        .ADDR_W(7), .DATA_W(8), .DEPTH(DEPTH), .INIT_EN(1'b1),
        .INIT_VAL(IV), .MAX_WR_STREAK(MAXS)
    ) dut (
        .clock(clock), .reset(reset),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
        .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data), .wr_req_mask(wr_req_mask),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
        .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready), .rd_resp_data(rd_resp_data),
        .init_done(init_done),
        .RW0_en(RW0_en), .RW0_wmode(RW0_wmode), .RW0_addr(RW0_addr),
        .RW0_wmask(RW0_wmask), .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata)
    );

    // SRAM macro: masked write, one-cycle read latency.
    logic [7:0] sram [0:DEPTH-1];
    always @(posedge clock) begin
        if (RW0_en) begin
            if (RW0_wmode) sram[RW0_addr] <= (sram[RW0_addr] & ~RW0_wmask) | (RW0_wdata & RW0_wmask);
            else           RW0_rdata <= sram[RW0_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    typedef struct { logic [7:0] d; int t; } rd_t;
    rd_t        expq[$];
    logic [7:0] shadow [0:DEPTH-1];
    int         mcyc   = 0;
    int         waitc  = 0;
    bit         held_v = 1'b0;
    logic [7:0] held_d = '0;
    bit         run, wr_hs, rd_hs, exp_v;
    rd_t        ent;

    always @(negedge clock) begin
        if (reset) begin
            chk("rst_ctrl_out", {init_done, wr_req_ready, rd_req_ready, rd_resp_valid, rd_resp_data}, 0);
            chk("rst_port_out", {RW0_en, RW0_wmode, RW0_addr, RW0_wmask, RW0_wdata}, 0);
            expq.delete();
            mcyc   = 0;
            waitc  = 0;
            held_v = 1'b0;
            for (int i = 0; i < DEPTH; i++) shadow[i] = IV;
        end else begin
            run   = (mcyc >= DEPTH);
            wr_hs = wr_req_valid && wr_req_ready;
            rd_hs = rd_req_valid && rd_req_ready;
            chk("init_done", init_done, run);
            if (!run) begin
                chk("sweep_port", {RW0_en, RW0_wmode, RW0_addr, RW0_wmask, RW0_wdata},
                    {1'b1, 1'b1, 7'(mcyc), 8'hFF, IV});
                chk("ready_in_init", {wr_req_ready, rd_req_ready}, 0);
            end else begin
                chk("single_grant", wr_hs && rd_hs, 0);
                chk("wr_ready", wr_req_ready, !rd_hs);
                if (!wr_req_valid) chk("rd_ready_elig", rd_req_ready, expq.size() < 3);
                if (rd_hs) chk("rd_cap", expq.size() < 3, 1);
                if (wr_hs)
                    chk("port_wr", {RW0_en, RW0_wmode, RW0_addr, RW0_wmask, RW0_wdata},
                        {1'b1, 1'b1, wr_req_addr, wr_req_mask, wr_req_data});
                else if (rd_hs)
                    chk("port_rd", {RW0_en, RW0_wmode, RW0_addr, RW0_wmask, RW0_wdata},
                        {1'b1, 1'b0, rd_req_addr, 8'h00, 8'h00});
                else
                    chk("port_idle", {RW0_en, RW0_wmode, RW0_addr, RW0_wmask, RW0_wdata}, 0);
                if (rd_req_valid && expq.size() < 3 && !rd_hs) waitc++;
                else waitc = 0;
                if (waitc > 0) chk("starve_bound", waitc <= MAXS, 1);
            end
            exp_v = (expq.size() > 0) && (expq[0].t <= mcyc - 2);
            chk("resp_valid", rd_resp_valid, exp_v);
            if (rd_resp_valid && exp_v) chk("resp_data", rd_resp_data, expq[0].d);
            if (held_v) chk("resp_hold", rd_resp_data, held_d);
            held_v = rd_resp_valid && !rd_resp_ready;
            held_d = rd_resp_data;
            if (rd_resp_valid && rd_resp_ready && exp_v) void'(expq.pop_front());
            if (run && wr_hs)
                shadow[wr_req_addr] = (shadow[wr_req_addr] & ~wr_req_mask) | (wr_req_data & wr_req_mask);
            if (run && rd_hs) begin
                ent.d = shadow[rd_req_addr];
                ent.t = mcyc;
                expq.push_back(ent);
            end
            mcyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_init();
        int rise = -1;
        bit saw  = 1'b0;
        for (int i = 0; i < DEPTH + 20 && rise < 0; i++) begin
            @(negedge clock);
            if (i == 0) chk("sweep_start", {RW0_en, RW0_wmode, RW0_addr}, {1'b1, 1'b1, 7'd0});
            if (rd_resp_valid) saw = 1'b1;
            if (init_done) rise = i;
        end
        chk("init_rise_cycle", rise, DEPTH);
        chk("no_resp_in_sweep", saw, 0);
        tick();
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] d, input logic [7:0] m);
        bit ok = 1'b0;
        wr_req_valid = 1'b1; wr_req_addr = a; wr_req_data = d; wr_req_mask = m;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clock);
            ok = wr_req_ready;
            tick();
        end
        wr_req_valid = 1'b0;
        chk("wr_accept_timeout", ok, 1);
    endtask

    task automatic do_read(input logic [6:0] a, output logic [7:0] d, output int lat);
        bit ok = 1'b0;
        int t0 = 0;
        rd_req_valid = 1'b1; rd_req_addr = a;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clock);
            ok = rd_req_ready;
            t0 = gcyc;
            tick();
        end
        rd_req_valid = 1'b0;
        chk("rd_accept_timeout", ok, 1);
        ok = 1'b0; d = '0; lat = -1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clock);
            if (rd_resp_valid && rd_resp_ready) begin
                ok = 1'b1; d = rd_resp_data; lat = gcyc - t0;
            end
            tick();
        end
        chk("rd_resp_timeout", ok, 1);
    endtask

    logic [7:0] rdat;
    int         lat, idx, n;
    logic [7:0] got [0:4];
    logic       gw, gr;
    bit         acc;

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        wait_init();

        do_read(7'd77, rdat, lat);
        chk("init_val_77", rdat, 8'hA5);
        chk("init_rd_latency", lat, 2);

        do_write(7'd3, 8'hFF, 8'hFF);
        do_write(7'd3, 8'h00, 8'h0F);
        do_read(7'd3, rdat, lat);
        chk("masked_write", rdat, 8'hF0);
        chk("masked_latency", lat, 2);

        do_write(7'd9, 8'h3C, 8'hFF);
        do_read(7'd9, rdat, lat);
        chk("read_after_write", rdat, 8'h3C);

        // Backpressure: 5 offered reads, response side stalled.
        for (int i = 0; i < 5; i++) do_write(7'(i), 8'(16 + i), 8'hFF);
        rd_resp_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            rd_req_valid = (idx < 5); rd_req_addr = 7'(idx);
            @(negedge clock);
            if (rd_req_valid && rd_req_ready) idx++;
            tick();
        end
        chk("bp_accepted", idx, 3);
        rd_resp_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            rd_req_valid = (idx < 5); rd_req_addr = 7'(idx);
            @(negedge clock);
            if (rd_req_valid && rd_req_ready) idx++;
            if (rd_resp_valid) begin got[n] = rd_resp_data; n++; end
            tick();
        end
        rd_req_valid = 1'b0;
        chk("bp_resp_count", n, 5);
        for (int i = 0; i < 5; i++) chk("bp_order", got[i], 8'(16 + i));
        repeat (4) tick();

        // Starvation bound: continuous writes plus one continuous read.
        wr_req_valid = 1'b1; rd_req_valid = 1'b1; rd_req_addr = 7'd5;
        for (int c = 0; c < 20; c++) begin
            wr_req_addr = 7'($urandom_range(64, 127));
            wr_req_data = 8'($urandom);
            wr_req_mask = 8'($urandom);
            @(negedge clock);
            gw = wr_req_ready; gr = rd_req_ready;
            chk("grant_pattern", {gw, gr}, (c % 5 == 4) ? 2'b01 : 2'b10);
            tick();
        end
        wr_req_valid = 1'b0; rd_req_valid = 1'b0;
        repeat (4) tick();

        // Random traffic on a small address window to provoke RAW hazards.
        for (int c = 0; c < 2000; c++) begin
            wr_req_valid  = ($urandom_range(0, 99) < 50);
            wr_req_addr   = 7'($urandom_range(0, 15));
            wr_req_data   = 8'($urandom);
            wr_req_mask   = 8'($urandom);
            rd_req_valid  = ($urandom_range(0, 99) < 60);
            rd_req_addr   = 7'($urandom_range(0, 15));
            rd_resp_ready = ($urandom_range(0, 99) < 70);
            tick();
        end
        wr_req_valid = 1'b0; rd_req_valid = 1'b0; rd_resp_ready = 1'b1;
        repeat (10) tick();

        // Reset asserted the cycle after a read grant.
        rd_req_valid = 1'b1; rd_req_addr = 7'd20;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clock);
            acc = rd_req_ready;
            tick();
        end
        chk("mid_rst_rd_accept", acc, 1);
        rd_req_valid = 1'b0;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        wait_init();
        do_read(7'd20, rdat, lat);
        chk("post_reset_sweep_val", rdat, 8'hA5);
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/sram_1rw_ctrl.md
# sram_1rw_ctrl

Request-side controller for a single-port (one RW port) synchronous SRAM macro with per-bit write mask and one-cycle read latency. It accepts independent read and write request streams over valid/ready, arbitrates them onto the single `RW0_*` port, and returns read data through a small response FIFO. After reset it optionally sweeps the whole array to a known value. It sits between a cache or predictor table pipeline and the generated SRAM array instance.

## Interface

- `ADDR_W`, 7, address width
- `DATA_W`, 8, data and mask width
- `DEPTH`, 128, number of entries; must be ≤ 2^ADDR_W
- `INIT_EN`, 1, when 1, run the post-reset initialization sweep
- `INIT_VAL`, 0, DATA_W-bit value written during the sweep
- `MAX_WR_STREAK`, 4, maximum consecutive write grants while an eligible read waits

- `clock`  in  1  sole clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `wr_req_valid` / `wr_req_ready`  in/out  1  write request handshake
- `wr_req_addr`  in  ADDR_W  write address
- `wr_req_data`  in  DATA_W  write data
- `wr_req_mask`  in  DATA_W  per-bit write enable
- `rd_req_valid` / `rd_req_ready`  in/out  1  read request handshake
- `rd_req_addr`  in  ADDR_W  read address
- `rd_resp_valid` / `rd_resp_ready`  out/in  1  read response handshake
- `rd_resp_data`  out  DATA_W  read data, returned in request order
- `init_done`  out  1  high once the array is usable
- `RW0_en`, `RW0_wmode`  out  1  SRAM enable and write mode
- `RW0_addr`  out  ADDR_W  SRAM address
- `RW0_wmask`, `RW0_wdata`  out  DATA_W  SRAM write mask and write data
- `RW0_rdata`  in  DATA_W  SRAM read data, valid the cycle after a read enable

## Operation

- The FSM has two states:
  - **INIT**, entered on reset when `INIT_EN`=1. A counter drives one write per cycle: `RW0_en`=1, `wmode`=1, `wmask`=all ones, `wdata`=`INIT_VAL`, addresses 0..DEPTH-1.
  - **RUN**. Entered the cycle after address DEPTH-1 is written, or directly out of reset when `INIT_EN`=0.
- `init_done` = (state == RUN). Both `*_req_ready` signals are 0 outside RUN.
- **Read eligibility.** `occ` is the response FIFO occupancy, depth 3. `inflight` is 1 when a read was issued in the previous cycle. A read is eligible when `occ + inflight < 3`.
  - `rd_req_ready` never depends combinationally on `rd_resp_ready`.
- **Arbitration in RUN.** Exactly one of read or write is granted per cycle.
  - Write wins by default.
  - Read wins if it is eligible and valid, and either no write is valid or `streak` == `MAX_WR_STREAK`.
  - `streak` increments on a write grant while an eligible read is valid. It clears on a read grant, or on any cycle where no eligible read is valid. It saturates at `MAX_WR_STREAK`.
- **Ready outputs.**
  - `wr_req_ready` = RUN && !(read granted).
  - `rd_req_ready` = RUN && eligible && !(write granted).
- **Port drive.** The port is combinational from the grant.
  - Write grant: `RW0_en`=1, `wmode`=1, with addr, mask and data taken from the request.
  - Read grant: `RW0_en`=1, `wmode`=0, `wmask`=0, `wdata`=0.
  - No grant: all port outputs are 0.
- **Read capture.** The cycle after a read grant, `RW0_rdata` is pushed into the FIFO. A write granted in that same cycle does not disturb the capture.
- **Response FIFO.** FIFO head drives `rd_resp_*`. Push and pop may occur in the same cycle.
- **Ordering.** Port order equals grant order. A read granted after a write to the same address returns the merged data: `(mask & data) | (~mask & old)`.
- **Reset mid-operation.** Reset clears the FIFO, `inflight`, `streak` and the FSM. Data for a read in flight at reset is discarded. With `INIT_EN`=1 the sweep restarts at address 0.

## Timing

- Reset values: `wr_req_ready`=0, `rd_req_ready`=0, `rd_resp_valid`=0, `rd_resp_data`=0, `init_done`=0, and all `RW0_*` outputs 0.
- Let cycle 0 be the first cycle with `reset` low. With `INIT_EN`=1, sweep writes occupy cycles 0..DEPTH-1 and `init_done`=1 from cycle DEPTH.
- Read latency: a request accepted in cycle t gives `rd_resp_valid`=1 in cycle t+2 at the earliest (SRAM in t+1, FIFO push at the end of t+1).
- Sustained throughput is one read per cycle while `rd_resp_ready`=1, since steady state has `occ`=1 and `inflight`=1.
- With `rd_resp_ready`=0, at most 3 reads are accepted before `rd_req_ready` drops. No response is ever dropped.
- `rd_resp_data` holds stable while `rd_resp_valid`=1 and `rd_resp_ready`=0.

## Test plan

- **Init sweep.** `INIT_EN`=1, `INIT_VAL`=0xA5; release reset → 128 consecutive full-mask writes to addresses 0..127, `init_done` rises at cycle 128, and a read of address 77 returns 0xA5.
- **Masked write.** Write addr 3 data 0xFF mask 0xFF, then data 0x00 mask 0x0F, then read addr 3 → response 0xF0 at request cycle + 2.
- **Backpressure.** Hold `rd_resp_ready`=0 and offer 5 reads to addresses 0..4 → exactly 3 accepted. Release `rd_resp_ready` → responses come in address order 0, 1, 2, then the remaining reads proceed.
- **Starvation bound.** Drive writes every cycle and a continuous read, with `MAX_WR_STREAK`=4 → grant pattern W,W,W,W,R repeating, and no read waits more than 4 cycles.
- **Read-after-write.** Write 0x3C to addr 9 in cycle t, read addr 9 in cycle t+1 → response 0x3C.
- **Reset mid-operation.** Assert reset in the cycle after a read grant → no `rd_resp_valid` after reset, FIFO empty, sweep restarts at address 0.
